// File: rtl/systolic_mac_pe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : systolic_mac_pe_if                                            |
// | Purpose  : Bundles the operand, control and chain signals of one         |
// |            systolic MAC processing element.                              |
// |   master : drives mode, valid_in, a_in, b_in, c_in;                       |
// |            observes a_out, b_out, valid_out, c_out, ovf                  |
// |   slave  : the processing element itself (mirror directions)            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface systolic_mac_pe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic [1:0]        mode;
  logic              valid_in;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [ACC_W-1:0]  c_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              valid_out;
  logic [ACC_W-1:0]  c_out;
  logic              ovf;

  modport master (
    output mode, valid_in, a_in, b_in, c_in,
    input  a_out, b_out, valid_out, c_out, ovf
  );

  modport slave (
    input  mode, valid_in, a_in, b_in, c_in,
    output a_out, b_out, valid_out, c_out, ovf
  );
endinterface
`default_nettype wire

// File: rtl/systolic_mac_pe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : systolic_mac_pe                                               |
// | Purpose  : Systolic-array MAC tile. Two-stage multiply/accumulate with    |
// |            signed/unsigned and wrap/saturate options, 1-cycle forwarding |
// |            of a/b/valid, and a c chain for preload and partial-sum drain.|
// | Ports    : clk  - clock, rising edge                                     |
// |            rst  - synchronous active-high reset                          |
// |            pe   - slave side of systolic_mac_pe_if (operands, mode,      |
// |                   chain input, forwarded operands, c_out, ovf)           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module systolic_mac_pe #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               rst,
  systolic_mac_pe_if.slave   pe
);

  localparam logic [1:0] MODE_ACCUM = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_DRAIN = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;
  localparam int         PROD_W     = 2 * DATA_W;
  localparam int         EXT_W      = ACC_W - PROD_W;

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("systolic_mac_pe: ACC_W must be at least 2*DATA_W");
  end

  logic [DATA_W-1:0] a_q, b_q;
  logic              valid_q;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              pvalid_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  c_q, c_d;

  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    sum;
  logic              add_ovf;
  logic [ACC_W-1:0]  sat_val;

  // Stage 1 multiplier: operands widened to the product width first so the
  // low PROD_W bits of the multiply are exact in either arithmetic.
  if (SIGNED != 0) begin : g_smul
    logic [PROD_W-1:0] a_sx, b_sx;
    assign a_sx   = {{DATA_W{pe.a_in[DATA_W-1]}}, pe.a_in};
    assign b_sx   = {{DATA_W{pe.b_in[DATA_W-1]}}, pe.b_in};
    assign prod_d = a_sx * b_sx;
  end else begin : g_umul
    assign prod_d = {{DATA_W{1'b0}}, pe.a_in} * {{DATA_W{1'b0}}, pe.b_in};
  end

  // Widen the registered product to accumulator width.
  if (EXT_W > 0 && SIGNED != 0) begin : g_sext
    assign prod_ext = {{EXT_W{prod_q[PROD_W-1]}}, prod_q};
  end else if (EXT_W > 0) begin : g_zext
    assign prod_ext = {{EXT_W{1'b0}}, prod_q};
  end else begin : g_noext
    assign prod_ext = prod_q;
  end

  assign sum = {1'b0, acc_q} + {1'b0, prod_ext};

  if (SIGNED != 0) begin : g_sovf
    // Carry into the sign bit differs from carry out exactly when both addends
    // share a sign and the result sign flips.
    assign add_ovf = sum[ACC_W] ^ sum[ACC_W-1] ^ acc_q[ACC_W-1] ^ prod_ext[ACC_W-1];
    // Signed overflow direction follows the (common) addend sign.
    assign sat_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
  end else begin : g_uovf
    assign add_ovf = sum[ACC_W];
    assign sat_val = '1;
  end

  // Stage 2: accumulator, overflow flag and chain register next state.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    c_d   = (pe.mode == MODE_DRAIN) ? pe.c_in : acc_q;
    if (pe.mode == MODE_CLEAR) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (pe.mode == MODE_LOAD) begin
      acc_d = pe.c_in;
      ovf_d = 1'b0;
    end else if (pvalid_q) begin
      // Reached in ACCUM and DRAIN so the last pair before a drain still lands.
      acc_d = sum[ACC_W-1:0];
      if (add_ovf) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) begin
          acc_d = sat_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      prod_q   <= '0;
      pvalid_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      c_q      <= '0;
    end else begin
      a_q      <= pe.a_in;
      b_q      <= pe.b_in;
      valid_q  <= pe.valid_in;
      prod_q   <= prod_d;
      pvalid_q <= pe.valid_in && (pe.mode == MODE_ACCUM);
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      c_q      <= c_d;
    end
  end

  assign pe.a_out     = a_q;
  assign pe.b_out     = b_q;
  assign pe.valid_out = valid_q;
  assign pe.c_out     = c_q;
  assign pe.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/systolic_mac_pe.md
# systolic_mac_pe

Parametrised systolic-array processing element. It multiplies the streamed operands `a_in` and `b_in` through a two-stage pipeline and accumulates the result into a wide accumulator, with selectable signed or unsigned arithmetic and wrap or saturate overflow. It forwards `a`, `b` and `valid` to its east and south neighbours with one cycle of delay. The accumulator can be preloaded, cleared, or bypassed so that partial sums drain along the `c` chain. It is the tile instantiated N×M times inside the matrix-multiply array.

## Interface
Parameters:
- `DATA_W`, default 8: operand width.
- `ACC_W`, default 24: accumulator and `c` chain width. Elaboration fails if `ACC_W < 2*DATA_W`.
- `SIGNED`, default 0: 1 selects two's-complement operands and accumulator; 0 selects unsigned.
- `SATURATE`, default 0: 1 clamps on overflow; 0 wraps modulo 2^ACC_W.

Ports:
- `clk`, input, 1: single clock, all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `mode`, input, 2: 00 ACCUM, 01 LOAD, 10 DRAIN, 11 CLEAR.
- `valid_in`, input, 1: `a_in`/`b_in` carry a real operand pair this cycle.
- `a_in`, input, DATA_W: row operand.
- `b_in`, input, DATA_W: column operand.
- `c_in`, input, ACC_W: preload value (LOAD) or upstream partial sum (DRAIN).
- `a_out`, output, DATA_W: `a_in` registered.
- `b_out`, output, DATA_W: `b_in` registered.
- `valid_out`, output, 1: `valid_in` registered.
- `c_out`, output, ACC_W: accumulator view or drained chain value.
- `ovf`, output, 1: sticky overflow flag.

## Operation
- Reset (`rst`=1 at an edge) zeroes `a_out`, `b_out`, `valid_out`, `c_out`, `ovf`, the product register, `p_valid` and the accumulator. Reset overrides every mode, including mid-accumulation.
- Forwarding: every cycle, `a_out`←`a_in`, `b_out`←`b_in`, `valid_out`←`valid_in`. This is independent of mode and `valid_in`.
- Stage 1:
  - `prod` ← `a_in`×`b_in`, full 2·DATA_W bits, signed or unsigned per `SIGNED`.
  - `p_valid` ← `valid_in` AND (`mode`==ACCUM).
- Stage 2 updates the accumulator, highest priority first:
  - CLEAR: `acc`←0 and `ovf`←0.
  - LOAD: `acc`←`c_in` and `ovf`←0.
  - Otherwise, if `p_valid`=1: `acc`←`acc` + ext(`prod`).
    - ext is sign-extension when `SIGNED`=1, zero-extension otherwise.
    - This applies in both ACCUM and DRAIN.
  - Otherwise `acc` holds.
- An in-flight product whose stage-2 edge sees CLEAR or LOAD is discarded.
- Overflow detection:
  - Unsigned: carry out of bit ACC_W-1.
  - Signed: both addends have the same sign and the result sign differs.
- On overflow:
  - `ovf`←1.
  - `SATURATE`=1: result clamps to the maximum (2^ACC_W-1 unsigned, 2^(ACC_W-1)-1 signed). For signed negative overflow it clamps to -2^(ACC_W-1).
  - `SATURATE`=0: result wraps.
- `c_out` register:
  - Mode DRAIN: `c_out`←`c_in`. This forms a one-register-per-PE shift chain; `acc` is not disturbed.
  - All other modes: `c_out`←`acc` as it stood before this edge's update.

## Timing
- Forwarding latency: 1 cycle.
- MAC latency: a pair sampled at edge k (with ACCUM and valid) is in `acc` after edge k+1 and is visible on `c_out` after edge k+2.
- Throughput: one MAC per cycle with no stalls. A back-to-back ACCUM stream accumulates every pair.
- LOAD or CLEAR at edge k: new `acc` after edge k, and `c_out` reflects it after edge k+1.
- DRAIN at edge k: `c_out` equals the `c_in` sampled at edge k. A chain of N PEs shifts out in N cycles.
- Switching ACCUM→DRAIN does not lose the last sampled pair; it still lands in `acc`.
- `ovf` is set on the same edge as the overflowing update and is cleared only by `rst`, CLEAR or LOAD.

## Test plan
1. **Reset.** Defaults. Accumulate (7,9), then assert `rst` for 1 cycle while `valid_in`=1 → next cycle all outputs are 0. A pair sampled during the `rst` cycle is never added.
2. **Unsigned dot product.** ACCUM with pairs (3,4), (5,6), (255,255) on consecutive cycles → `c_out` reads 12, 42, 65067 on cycles k+2, k+3, k+4. `a_out`/`b_out`/`valid_out` mirror the inputs delayed 1 cycle.
3. **Preload and discard.** LOAD with `c_in`=100, then ACCUM (2,3) → `c_out`=106. Next, sample (10,10) in ACCUM and then LOAD `c_in`=5 on the following cycle → `c_out`=5; the 100 product is dropped.
4. **Drain.** With `acc`=106, DRAIN for 2 cycles with `c_in`=0xABCDE, then 0x12345 → `c_out` shows 0xABCDE, then 0x12345. Return to ACCUM → `c_out`=106 again.
5. **Signed.** `SIGNED`=1. CLEAR, then (-128,-128), then (-1,5) → `c_out` reads 16384, then 16379. Then LOAD -10 and accumulate (3,2) → -4.
6. **Overflow.** `ACC_W`=16, unsigned. LOAD 0xFFF0, then (4,8):
   - `SATURATE`=1 → `c_out`=0xFFFF, `ovf`=1.
   - `SATURATE`=0 → `c_out`=0x0010, `ovf`=1.
   - CLEAR afterwards → `ovf`=0.
